// File: rtl/ddf_split_if.sv
// Bundle of token-stream, NDA and data-FIFO signals around the flux splitter.
// master is the splitter side, slave is the FIFO/environment side.
interface ddf_split_if #(
    parameter int PORTS = 2,
    parameter int FLUX  = 2,
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0]       in0_data;
    logic                   in0_empty;
    logic                   in0_read;
    logic [WIDTH-1:0]       nda_data;
    logic [FLUX-1:0]        nda_full;
    logic [FLUX-1:0]        nda_wr;
    logic [WIDTH*PORTS-1:0] out_data;
    logic [PORTS*FLUX-1:0]  out_full;
    logic [PORTS*FLUX-1:0]  out_wr;
    logic [FLUX-1:0]        done;
    logic                   err;

    modport master (
        input  in0_data, in0_empty, nda_full, out_full,
        output in0_read, nda_data, nda_wr, out_data, out_wr, done, err
    );

    modport slave (
        output in0_data, in0_empty, nda_full, out_full,
        input  in0_read, nda_data, nda_wr, out_data, out_wr, done, err
    );
endinterface

// File: rtl/ddf_split.sv
// Splits a tagged packet stream into per-flux NDA header FIFOs and per-port data FIFOs.
// state  | meaning
// S_HDR  | next popped token is a header {tag, N}
// S_DATA | routing data tokens of flux cur_tag, grp groups left, next lane = port
module ddf_split #(
    parameter int PORTS = 2,
    parameter int FLUX  = 2,
    parameter int WIDTH = 8
) (
    input logic         ck,
    input logic         rst,
    ddf_split_if.master bus
);
    localparam int TAG_WIDTH = $clog2(FLUX);
    localparam int P         = WIDTH - TAG_WIDTH;
    localparam int PW        = (PORTS > 1) ? $clog2(PORTS) : 1;

    localparam logic [0:0] S_HDR  = 1'b0;
    localparam logic [0:0] S_DATA = 1'b1;

    localparam logic [TAG_WIDTH:0] FLUX_LIM  = (TAG_WIDTH + 1)'(FLUX);
    localparam logic [PW-1:0]      PORT_LAST = PW'(PORTS - 1);
    localparam logic [P-1:0]       GRP_ONE   = P'(1);

    logic [0:0]           state, state_nxt;
    logic [TAG_WIDTH-1:0] cur_tag, tag_nxt;
    logic [P-1:0]         grp, grp_nxt;
    logic [PW-1:0]        port, port_nxt;
    logic                 err_q, err_set;

    logic [TAG_WIDTH-1:0] tag_in;
    logic [P-1:0]         len_in;
    logic                 tag_ok;

    logic                   in0_read;
    logic [WIDTH-1:0]       nda_data;
    logic [FLUX-1:0]        nda_wr;
    logic [FLUX-1:0]        done;
    logic [WIDTH*PORTS-1:0] out_data;
    logic [PORTS*FLUX-1:0]  out_wr;
    logic                   data_wr;

    assign tag_in = bus.in0_data[WIDTH-1:P];
    assign len_in = bus.in0_data[P-1:0];
    assign tag_ok = {1'b0, tag_in} < FLUX_LIM;

    always_comb begin
        in0_read  = 1'b0;
        nda_data  = '0;
        nda_wr    = '0;
        done      = '0;
        out_data  = '0;
        out_wr    = '0;
        data_wr   = 1'b0;
        err_set   = 1'b0;
        state_nxt = state;
        tag_nxt   = cur_tag;
        grp_nxt   = grp;
        port_nxt  = port;

        // Reset gates every strobe so nothing leaks while rst is held.
        if (!rst && !bus.in0_empty) begin
            case (state)
                S_HDR: begin
                    if (!tag_ok) begin
                        in0_read = 1'b1;
                        err_set  = 1'b1;
                    end else if (!bus.nda_full[tag_in]) begin
                        in0_read       = 1'b1;
                        nda_wr[tag_in] = 1'b1;
                        nda_data       = bus.in0_data;
                        tag_nxt        = tag_in;
                        grp_nxt        = len_in;
                        port_nxt       = '0;
                        if (len_in == '0) begin
                            done[tag_in] = 1'b1;
                        end else begin
                            state_nxt = S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    for (int f = 0; f < FLUX; f++) begin
                        for (int p = 0; p < PORTS; p++) begin
                            if (cur_tag == TAG_WIDTH'(f) && port == PW'(p) &&
                                !bus.out_full[p + f*PORTS]) begin
                                data_wr                     = 1'b1;
                                in0_read                    = 1'b1;
                                out_wr[p + f*PORTS]         = 1'b1;
                                out_data[p*WIDTH +: WIDTH]  = bus.in0_data;
                            end
                        end
                    end
                    if (data_wr) begin
                        // Misrouted tokens still follow the open packet, only flagged.
                        if (tag_in != cur_tag) begin
                            err_set = 1'b1;
                        end
                        if (port == PORT_LAST) begin
                            port_nxt = '0;
                            grp_nxt  = grp - GRP_ONE;
                            if (grp == GRP_ONE) begin
                                done[cur_tag] = 1'b1;
                                state_nxt     = S_HDR;
                            end
                        end else begin
                            port_nxt = port + PW'(1);
                        end
                    end
                end
                default: state_nxt = S_HDR;
            endcase
        end
    end

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            state   <= S_HDR;
            cur_tag <= '0;
            grp     <= '0;
            port    <= '0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_nxt;
            cur_tag <= tag_nxt;
            grp     <= grp_nxt;
            port    <= port_nxt;
            err_q   <= err_q | err_set;
        end
    end

    assign bus.in0_read = in0_read;
    assign bus.nda_data = nda_data;
    assign bus.nda_wr   = nda_wr;
    assign bus.out_data = out_data;
    assign bus.out_wr   = out_wr;
    assign bus.done     = done;
    assign bus.err      = err_q;
endmodule

// File: tb/tb_ddf_split.sv
// Bench for ddf_split (PORTS=2, FLUX=2, WIDTH=8): directed packet scenarios plus
// randomized packets checked against a token-level routing model.
module tb_ddf_split;
    logic ck;
    logic rst;
    int   checks;
    int   errors;

    ddf_split_if #(.PORTS(2), .FLUX(2), .WIDTH(8)) bus ();

    ddf_split #(.PORTS(2), .FLUX(2), .WIDTH(8)) dut (
        .ck  (ck),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [7:0] d;
        logic       hdr;
        logic [1:0] idx;
        logic       last;
        logic       tag;
    } tok_t;

    initial begin
        ck = 1'b0;
        forever #5 ck = ~ck;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [8:0] strb();
        return {bus.in0_read, bus.nda_wr, bus.out_wr, bus.done};
    endfunction

    task automatic cyc_end();
        @(posedge ck);
        #1;
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        bus.in0_empty = 1'b0;
        bus.in0_data  = 8'h83;
        bus.nda_full  = 2'b00;
        bus.out_full  = 4'b0000;
        @(negedge ck);
        checks++;
        if (strb() !== 9'h000) begin
            errors++;
            $display("FAIL reset_strobes got %h exp %h", strb(), 9'h000);
        end
        checks++;
        if ({bus.nda_data, bus.out_data} !== 24'h0) begin
            errors++;
            $display("FAIL reset_data got %h exp 0", {bus.nda_data, bus.out_data});
        end
        checks++;
        if (bus.err !== 1'b0) begin
            errors++;
            $display("FAIL reset_err got %b exp 0", bus.err);
        end
        bus.in0_empty = 1'b1;
        rst = 1'b0;
        cyc_end();
    endtask

    task automatic test_single_packet();
        logic [7:0]  d;
        logic [3:0]  ew;
        logic [15:0] el;
        logic [1:0]  ed;
        bus.in0_empty = 1'b0;
        bus.in0_data  = 8'h83;
        @(negedge ck);
        checks++;
        if (strb() !== {1'b1, 2'b10, 4'b0000, 2'b00}) begin
            errors++;
            $display("FAIL pkt_hdr_strobes got %h exp %h", strb(), {1'b1, 2'b10, 4'b0000, 2'b00});
        end
        checks++;
        if (bus.nda_data !== 8'h83) begin
            errors++;
            $display("FAIL pkt_hdr_data got %h exp 83", bus.nda_data);
        end
        cyc_end();
        for (int k = 0; k < 6; k++) begin
            d  = 8'h81 + 8'(k);
            bus.in0_data = d;
            ew = (k % 2 == 1) ? 4'b1000 : 4'b0100;
            el = (k % 2 == 1) ? {d, 8'h00} : {8'h00, d};
            ed = (k == 5) ? 2'b10 : 2'b00;
            @(negedge ck);
            checks++;
            if (strb() !== {1'b1, 2'b00, ew, ed}) begin
                errors++;
                $display("FAIL pkt_data_strobes k=%0d got %h exp %h", k, strb(), {1'b1, 2'b00, ew, ed});
            end
            checks++;
            if ({bus.nda_data, bus.out_data} !== {8'h00, el}) begin
                errors++;
                $display("FAIL pkt_data_lanes k=%0d got %h exp %h", k, {bus.nda_data, bus.out_data}, {8'h00, el});
            end
            cyc_end();
        end
        bus.in0_empty = 1'b1;
        checks++;
        if (bus.err !== 1'b0) begin
            errors++;
            $display("FAIL pkt_err got %b exp 0", bus.err);
        end
    endtask

    task automatic test_zero_and_stall();
        bus.in0_empty = 1'b0;
        bus.in0_data  = 8'h00;
        @(negedge ck);
        checks++;
        if (strb() !== {1'b1, 2'b01, 4'b0000, 2'b01}) begin
            errors++;
            $display("FAIL zero_hdr got %h exp %h", strb(), {1'b1, 2'b01, 4'b0000, 2'b01});
        end
        cyc_end();
        bus.in0_data = 8'h02;
        @(negedge ck);
        checks++;
        if ({strb(), bus.nda_data} !== {1'b1, 2'b01, 4'b0000, 2'b00, 8'h02}) begin
            errors++;
            $display("FAIL zero_next_is_hdr got %h exp %h", {strb(), bus.nda_data}, {1'b1, 2'b01, 4'b0000, 2'b00, 8'h02});
        end
        cyc_end();
        bus.in0_data = 8'h11;
        @(negedge ck);
        checks++;
        if (strb() !== {1'b1, 2'b00, 4'b0001, 2'b00}) begin
            errors++;
            $display("FAIL stall_first got %h exp %h", strb(), {1'b1, 2'b00, 4'b0001, 2'b00});
        end
        cyc_end();
        // target bit 1 full, plus unrelated FIFOs full to show they don't matter
        bus.in0_data = 8'h12;
        bus.out_full = 4'b1110;
        bus.nda_full = 2'b11;
        for (int k = 0; k < 3; k++) begin
            @(negedge ck);
            checks++;
            if (strb() !== 9'h000) begin
                errors++;
                $display("FAIL stall_hold k=%0d got %h exp 0", k, strb());
            end
            cyc_end();
        end
        bus.out_full = 4'b1101;
        @(negedge ck);
        checks++;
        if ({strb(), bus.out_data} !== {1'b1, 2'b00, 4'b0010, 2'b00, 8'h12, 8'h00}) begin
            errors++;
            $display("FAIL stall_release got %h exp %h", {strb(), bus.out_data}, {1'b1, 2'b00, 4'b0010, 2'b00, 8'h12, 8'h00});
        end
        cyc_end();
        bus.out_full = 4'b0000;
        bus.nda_full = 2'b00;
        bus.in0_data = 8'h13;
        @(negedge ck);
        checks++;
        if (strb() !== {1'b1, 2'b00, 4'b0001, 2'b00}) begin
            errors++;
            $display("FAIL stall_g2p0 got %h exp %h", strb(), {1'b1, 2'b00, 4'b0001, 2'b00});
        end
        cyc_end();
        bus.in0_data = 8'h14;
        @(negedge ck);
        checks++;
        if (strb() !== {1'b1, 2'b00, 4'b0010, 2'b01}) begin
            errors++;
            $display("FAIL stall_done got %h exp %h", strb(), {1'b1, 2'b00, 4'b0010, 2'b01});
        end
        cyc_end();
        bus.in0_empty = 1'b1;
    endtask

    task automatic test_tag_mismatch();
        bus.in0_empty = 1'b0;
        bus.in0_data  = 8'h81;
        @(negedge ck);
        checks++;
        if (strb() !== {1'b1, 2'b10, 4'b0000, 2'b00}) begin
            errors++;
            $display("FAIL mis_hdr got %h exp %h", strb(), {1'b1, 2'b10, 4'b0000, 2'b00});
        end
        cyc_end();
        bus.in0_data = 8'h05;
        @(negedge ck);
        checks++;
        if ({strb(), bus.out_data} !== {1'b1, 2'b00, 4'b0100, 2'b00, 8'h00, 8'h05}) begin
            errors++;
            $display("FAIL mis_route got %h exp %h", {strb(), bus.out_data}, {1'b1, 2'b00, 4'b0100, 2'b00, 8'h00, 8'h05});
        end
        cyc_end();
        checks++;
        if (bus.err !== 1'b1) begin
            errors++;
            $display("FAIL mis_err_rise got %b exp 1", bus.err);
        end
        bus.in0_data = 8'h82;
        @(negedge ck);
        checks++;
        if (strb() !== {1'b1, 2'b00, 4'b1000, 2'b10}) begin
            errors++;
            $display("FAIL mis_second got %h exp %h", strb(), {1'b1, 2'b00, 4'b1000, 2'b10});
        end
        cyc_end();
        bus.in0_empty = 1'b1;
        repeat (3) cyc_end();
        checks++;
        if (bus.err !== 1'b1) begin
            errors++;
            $display("FAIL mis_err_sticky got %b exp 1", bus.err);
        end
    endtask

    task automatic test_reset_mid_packet();
        bus.in0_empty = 1'b0;
        bus.in0_data  = 8'h83;
        cyc_end();
        bus.in0_data = 8'h81;
        cyc_end();
        bus.in0_data = 8'h82;
        cyc_end();
        bus.in0_data = 8'h83;
        rst = 1'b1;
        #1;
        checks++;
        if ({strb(), bus.nda_data, bus.out_data} !== 33'h0) begin
            errors++;
            $display("FAIL midrst_outputs got %h exp 0", {strb(), bus.nda_data, bus.out_data});
        end
        @(negedge ck);
        checks++;
        if (bus.err !== 1'b0) begin
            errors++;
            $display("FAIL midrst_err got %b exp 0", bus.err);
        end
        cyc_end();
        rst = 1'b0;
        bus.in0_data = 8'h84;
        @(negedge ck);
        checks++;
        if ({strb(), bus.nda_data} !== {1'b1, 2'b10, 4'b0000, 2'b00, 8'h84}) begin
            errors++;
            $display("FAIL midrst_hdr got %h exp %h", {strb(), bus.nda_data}, {1'b1, 2'b10, 4'b0000, 2'b00, 8'h84});
        end
        cyc_end();
        bus.in0_empty = 1'b1;
    endtask

    task automatic test_nda_backpressure();
        rst = 1'b1;
        #1;
        rst = 1'b0;
        bus.nda_full  = 2'b01;
        bus.in0_empty = 1'b0;
        bus.in0_data  = 8'h02;
        for (int k = 0; k < 4; k++) begin
            @(negedge ck);
            checks++;
            if (strb() !== 9'h000) begin
                errors++;
                $display("FAIL nda_hold k=%0d got %h exp 0", k, strb());
            end
            cyc_end();
        end
        bus.nda_full = 2'b00;
        @(negedge ck);
        checks++;
        if ({strb(), bus.nda_data} !== {1'b1, 2'b01, 4'b0000, 2'b00, 8'h02}) begin
            errors++;
            $display("FAIL nda_release got %h exp %h", {strb(), bus.nda_data}, {1'b1, 2'b01, 4'b0000, 2'b00, 8'h02});
        end
        cyc_end();
        bus.in0_empty = 1'b1;
    endtask

    task automatic test_random();
        tok_t        q[$];
        tok_t        t;
        int          n;
        int          cyc;
        logic        tg;
        logic        full_t;
        logic        rd;
        logic [8:0]  es;
        logic [7:0]  en;
        logic [15:0] eo;
        rst = 1'b1;
        #1;
        rst = 1'b0;
        for (int pk = 0; pk < 40; pk++) begin
            tg = 1'($urandom_range(0, 1));
            n  = $urandom_range(0, 3);
            q.push_back('{d: {tg, 7'(n)}, hdr: 1'b1, idx: {1'b0, tg}, last: (n == 0), tag: tg});
            for (int g = 0; g < n; g++) begin
                for (int p = 0; p < 2; p++) begin
                    q.push_back('{d: {tg, 7'($urandom)}, hdr: 1'b0, idx: 2'(p + 2*tg),
                                  last: (g == n-1 && p == 1), tag: tg});
                end
            end
        end
        cyc = 0;
        while (q.size() > 0 && cyc < 4000) begin
            t = q[0];
            bus.in0_empty = ($urandom_range(0, 3) == 0);
            bus.in0_data  = bus.in0_empty ? 8'($urandom) : t.d;
            bus.out_full  = 4'($urandom) & 4'($urandom);
            bus.nda_full  = 2'($urandom) & 2'($urandom);
            full_t = t.hdr ? bus.nda_full[t.idx[0]] : bus.out_full[t.idx];
            rd = !bus.in0_empty && !full_t;
            es = {rd,
                  (rd && t.hdr)  ? 2'(1 << t.idx[0]) : 2'b00,
                  (rd && !t.hdr) ? 4'(1 << t.idx)    : 4'b0000,
                  (rd && t.last) ? 2'(1 << t.tag)    : 2'b00};
            en = (rd && t.hdr) ? t.d : 8'h00;
            eo = (rd && !t.hdr) ? (t.idx[0] ? {t.d, 8'h00} : {8'h00, t.d}) : 16'h0000;
            @(negedge ck);
            checks++;
            if (strb() !== es) begin
                errors++;
                $display("FAIL rnd_strobes cyc=%0d got %h exp %h", cyc, strb(), es);
            end
            checks++;
            if ({bus.nda_data, bus.out_data} !== {en, eo}) begin
                errors++;
                $display("FAIL rnd_data cyc=%0d got %h exp %h", cyc, {bus.nda_data, bus.out_data}, {en, eo});
            end
            if (rd) void'(q.pop_front());
            cyc_end();
            cyc++;
        end
        bus.in0_empty = 1'b1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL rnd_timeout tokens_left=%0d exp 0", q.size());
        end
        checks++;
        if (bus.err !== 1'b0) begin
            errors++;
            $display("FAIL rnd_err got %b exp 0", bus.err);
        end
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst           = 1'b1;
        bus.in0_empty = 1'b1;
        bus.in0_data  = 8'h00;
        bus.nda_full  = 2'b00;
        bus.out_full  = 4'b0000;
        test_reset();
        test_single_packet();
        test_zero_and_stall();
        test_tag_mismatch();
        test_reset_mid_packet();
        test_nda_backpressure();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ddf_split.md
DDF_SPLIT -- requirements
Module: ddf_split

Interface
REQ-001 SHALL have parameter PORTS, 2, data ports per flux (>=1).
REQ-002 SHALL have parameter FLUX, 2, number of fluxes (>=2).
REQ-003 SHALL have parameter WIDTH, 8, token width.
REQ-004 SHALL derive the following widths:
- TAG_WIDTH = clog2(FLUX).
- P = WIDTH-TAG_WIDTH.
- Token = {tag[WIDTH-1:P], payload[P-1:0]}.
REQ-005 ck  in  1  clock, rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 in0_data  in  WIDTH  tagged input token stream.
REQ-008 in0_empty  in  1  input FIFO empty.
REQ-009 in0_read  out  1  pop input FIFO.
REQ-010 nda_data  out  WIDTH  header token to the per-flux NDA FIFO.
REQ-011 nda_full  in  FLUX  NDA FIFO full, bit f = flux f.
REQ-012 nda_wr  out  FLUX  NDA FIFO write, bit f = flux f.
REQ-013 out_data  out  WIDTH*PORTS  lane p = bits [p*WIDTH +: WIDTH], shared by all fluxes.
REQ-014 out_full  in  PORTS*FLUX  data FIFO full, bit p+f*PORTS.
REQ-015 out_wr  out  PORTS*FLUX  data FIFO write, bit p+f*PORTS.
REQ-016 done  out  FLUX  1-cycle pulse when a packet of flux f completes.
REQ-017 err  out  1  sticky protocol error flag.

Function
REQ-018 SHALL define the input packet format as follows:
- One header token {tag, N}.
- Then N groups of PORTS data tokens; token k of a group goes to port k of flux tag.
REQ-019 SHALL use FSM states HDR and DATA, and SHALL hold registers cur_tag, grp (P bits) and port (max(1,clog2(PORTS)) bits).
REQ-020 SHALL drive all strobes combinationally in the same cycle:
- in0_read, nda_wr, out_wr and done are decoded from current inputs and state.
- A token is consumed and written in one cycle, with zero latency.
- Throughput is 1 token/cycle.
REQ-021 In HDR with in0_empty=0, tag<FLUX and nda_full[tag]=0, it SHALL do the following:
- Assert in0_read and nda_wr[tag].
- Drive nda_data=in0_data.
- Latch cur_tag=tag, grp=N, port=0.
REQ-022 In HDR with N=0, it SHALL assert done[tag] in the header cycle and remain in HDR; otherwise it SHALL go to DATA.
REQ-023 In HDR with tag>=FLUX and in0_empty=0, it SHALL pop the token (in0_read=1) without any write, set err, and remain in HDR.
REQ-024 In HDR with nda_full[tag]=1, it SHALL hold in0_read=0 and nda_wr=0 and leave the state unchanged.
REQ-025 In DATA, the target is index i=port+cur_tag*PORTS; with in0_empty=0 and out_full[i]=0 it SHALL do the following:
- Assert in0_read and out_wr[i].
- Drive lane port of out_data with in0_data.
- Advance the port counter.
REQ-026 In DATA, when port=PORTS-1 on a write, it SHALL wrap port to 0 and decrement grp.
REQ-027 When grp=1 and port=PORTS-1 on a write, it SHALL assert done[cur_tag] and go to HDR.
REQ-028 In DATA with out_full[i]=1 or in0_empty=1, it SHALL hold all strobes at 0 and leave the counters unchanged; the stall length is unbounded.
REQ-029 A data token whose tag field is not equal to cur_tag SHALL still be routed to cur_tag and SHALL set err.
REQ-030 Full/empty on non-target FIFOs SHALL have no effect.
REQ-031 At most one bit of nda_wr|out_wr SHALL be high per cycle.
REQ-032 out_data lanes not being written, and nda_data when nda_wr=0, SHALL be 0.
REQ-033 err SHALL stay 1 until reset.

Reset
REQ-034 On rst=1 (async), it SHALL go to state HDR with cur_tag=0, grp=0, port=0, err=0.
REQ-035 With rst=1, all strobes (in0_read, nda_wr, out_wr, done) SHALL be 0 regardless of other inputs.
REQ-036 Reset mid-packet SHALL abandon the packet; the next token popped after reset is treated as a header.

Verification (PORTS=2, FLUX=2, WIDTH=8, P=7)
REQ-037 Header 0x83 then tokens 0x81..0x86, no backpressure:
- Header cycle: nda_wr=2'b10, nda_data=0x83.
- Next six cycles: out_wr toggles 4'b0100, 4'b1000, ...
- Lane 0 carries 0x81/0x83/0x85; lane 1 carries 0x82/0x84/0x86.
- done=2'b10 with the 6th write; err=0.
REQ-038 Header 0x00: nda_wr=2'b01 and done=2'b01 in the same cycle; FSM stays HDR; the next token 0x02 is taken as a header.
REQ-039 Header 0x02, then out_full[1]=1 for 3 cycles while the 2nd token is waiting:
- in0_read=0 and out_wr=0 for those 3 cycles.
- The write to bit 1 happens in the cycle out_full[1] drops.
REQ-040 Header 0x81, then tokens 0x05,0x82: both are written to flux 1 (bits 2 and 3), and err rises with the 0x05 write and stays 1.
REQ-041 rst pulse after 2 of 6 tokens of a 0x83 packet: outputs are 0 during reset, and next token 0x84 produces nda_wr[1] with nda_data=0x84.
REQ-042 nda_full[0]=1 with header 0x02 pending: no pop for 4 cycles; nda_wr[0] asserts in the cycle nda_full[0] drops.
